// File: rtl/microseq_fsm.sv
// Microprogrammed sequencer: a writable per-state control store picks INC/ZERO/DISP/HOLD,
// and DISP looks the successor up in one of NUM_DISP writable y-indexed dispatch tables.
module microseq_fsm #(
  parameter int STATE_W  = 4,
  parameter int IN_W     = 2,
  parameter int NUM_DISP = 2,
  parameter int STEP_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [IN_W-1:0]    y,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_sel,
  input  logic [STATE_W-1:0] cfg_addr,
  input  logic [STATE_W+1:0] cfg_data,
  output logic [STATE_W-1:0] curr_state,
  output logic [STATE_W-1:0] next_state,
  output logic               dispatched,
  output logic [STEP_W-1:0]  step_count
);

  localparam int DEPTH  = 1 << STATE_W;
  localparam int TDEPTH = 1 << IN_W;

  typedef enum logic [1:0] {
    ACT_INC  = 2'd0,
    ACT_ZERO = 2'd1,
    ACT_DISP = 2'd2,
    ACT_HOLD = 2'd3
  } act_e;

  typedef struct packed {
    logic [1:0] tsel;
    act_e       op;
  } cs_entry_t;

  cs_entry_t          r_cs  [DEPTH];
  logic [STATE_W-1:0] r_tbl [NUM_DISP][TDEPTH];
  logic [STATE_W-1:0] r_state;
  logic [STEP_W-1:0]  r_step;
  logic               r_disp;

  cs_entry_t          w_entry;
  logic [STATE_W-1:0] w_next;
  logic [IN_W-1:0]    w_taddr;

  assign w_entry = r_cs[r_state];
  assign w_taddr = cfg_addr[IN_W-1:0];

  // y is only looked at under DISP; an out-of-range table select leaves w_next at zero
  always_comb begin
    w_next = '0;
    case (w_entry.op)
      ACT_INC:  w_next = r_state + 1'b1;
      ACT_ZERO: w_next = '0;
      ACT_HOLD: w_next = r_state;
      ACT_DISP: begin
        for (int k = 0; k < NUM_DISP; k++)
          if (w_entry.tsel == 2'(k)) w_next = r_tbl[k][y];
      end
      default:  w_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_step  <= '0;
      r_disp  <= 1'b0;
    end else if (en) begin
      r_state <= w_next;
      r_step  <= r_step + 1'b1;
      r_disp  <= (w_entry.op == ACT_DISP);
    end else begin
      r_disp  <= 1'b0;
    end
  end

  // Writes land at the edge, so the transition taken on that edge still sees old contents
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_cs[i] <= '{tsel: 2'd0, op: ACT_INC};
      for (int k = 0; k < NUM_DISP; k++)
        for (int i = 0; i < TDEPTH; i++)
          r_tbl[k][i] <= STATE_W'(i);
    end else if (cfg_we) begin
      if (cfg_sel == 3'd0)
        r_cs[cfg_addr] <= cs_entry_t'(cfg_data[3:0]);
      for (int k = 0; k < NUM_DISP; k++)
        if (cfg_sel == 3'(k + 1))
          r_tbl[k][w_taddr] <= cfg_data[STATE_W-1:0];
    end
  end

  assign curr_state = r_state;
  assign next_state = w_next;
  assign dispatched = r_disp;
  assign step_count = r_step;

endmodule
